// File: rtl/axon_scheduler.sv
// Per-time-step spike sequencer: latches the axon spike vector on tick and issues
// each spiking axon to synapse_connection in ascending order, one at a time.
module axon_scheduler #(
   parameter int NUM_AXONS = 256,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic [NUM_AXONS-1:0]           axon_spikes,
   input  logic                           synap_con_done,
   input  logic                           err_clr,
   output logic [$clog2(NUM_AXONS)-1:0]   axon_number,
   output logic                           synap_enable,
   output logic                           busy,
   output logic                           step_done,
   output logic [$clog2(NUM_AXONS):0]     spike_count,
   output logic                           tick_overrun,
   output logic                           timeout_err
);

   localparam int IW = $clog2(NUM_AXONS);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_AXONS - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

   // Handshake: synap_enable rises with a stable axon_number and stays high until the
   // edge that samples synap_con_done (or the watchdog expires); done is ignored otherwise.
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_t;

   state_t               state;
   logic [NUM_AXONS-1:0] spikes;
   logic [IW-1:0]        index;
   logic [WW-1:0]        watchdog;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         spikes       <= '0;
         index        <= '0;
         watchdog     <= '0;
         axon_number  <= '0;
         synap_enable <= 1'b0;
         busy         <= 1'b0;
         step_done    <= 1'b0;
         spike_count  <= '0;
         tick_overrun <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         // Clear first so a set event later in this block takes priority.
         if (err_clr) begin
            tick_overrun <= 1'b0;
            timeout_err  <= 1'b0;
         end
         if (tick && state != S_IDLE) tick_overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (tick) begin
                  spikes      <= axon_spikes;
                  index       <= '0;
                  spike_count <= '0;
                  busy        <= 1'b1;
                  state       <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (spikes[index]) begin
                  axon_number  <= index;
                  synap_enable <= 1'b1;
                  watchdog     <= '0;
                  spike_count  <= spike_count + 1'b1;
                  state        <= S_WAIT;
               end else if (index == LAST_IDX) begin
                  step_done <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  index <= index + 1'b1;
               end
            end
            S_WAIT: begin
               if (synap_con_done || watchdog == WD_LAST) begin
                  synap_enable  <= 1'b0;
                  spikes[index] <= 1'b0;
                  // Done arriving on the expiry cycle still counts as a clean finish.
                  if (!synap_con_done) timeout_err <= 1'b1;
                  if (index == LAST_IDX) begin
                     step_done <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     index <= index + 1'b1;
                     state <= S_SCAN;
                  end
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            S_DONE: begin
               step_done <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/axon_scheduler.md
# axon_scheduler

Per-time-step spike sequencer that drives `synapse_connection` in the single-core simulator. On each `tick` it latches the core's incoming axon spike vector and scans axons in ascending order. For every spiking axon it presents the axon number to `synapse_connection` and holds `enable` until that block reports `synap_con_done`. After the whole vector has been processed it signals end of step. A per-axon watchdog and sticky error flags guard against a stalled downstream block.

## Interface
Parameters:
- NUM_AXONS, 256, number of axons; power of two, ≥ 2
- TIMEOUT, 1024, maximum WAIT cycles per axon before abort; ≥ 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- tick  input  1  time-step start pulse
- axon_spikes  input  NUM_AXONS  spike vector; sampled only on an accepted tick
- synap_con_done  input  1  completion pulse from synapse_connection
- err_clr  input  1  clears sticky error flags
- axon_number  output  $clog2(NUM_AXONS)  axon presented downstream
- synap_enable  output  1  enable to synapse_connection
- busy  output  1  high in any state other than IDLE
- step_done  output  1  one-cycle end-of-step pulse
- spike_count  output  $clog2(NUM_AXONS)+1  axons issued in the current/last step
- tick_overrun  output  1  sticky; tick arrived while busy
- timeout_err  output  1  sticky; an axon hit TIMEOUT

## Operation
- All outputs registered. Reset (rst=0 at an edge) forces: state IDLE, spike buffer 0, scan index 0, axon_number 0, synap_enable 0, busy 0, step_done 0, spike_count 0, tick_overrun 0, timeout_err 0. Reset mid-step aborts without a step_done pulse.
- States: IDLE, SCAN, WAIT, DONE.
- IDLE: tick=1 → buffer ← axon_spikes, index ← 0, spike_count ← 0, busy ← 1, → SCAN.
- SCAN: examine buffer[index].
  - Bit set → axon_number ← index, synap_enable ← 1, watchdog ← 0, spike_count += 1, → WAIT; index unchanged.
  - Bit clear, index < NUM_AXONS-1 → index += 1.
  - Bit clear, index = NUM_AXONS-1 → step_done ← 1, → DONE.
- WAIT: axon_number and synap_enable are held stable; watchdog increments each cycle.
  - synap_con_done=1 → synap_enable ← 0, buffer[index] ← 0. If index = NUM_AXONS-1 → step_done ← 1, → DONE; else index += 1, → SCAN.
  - Watchdog reaches TIMEOUT-1 without done → same exit as above, and timeout_err ← 1.
  - Done and timeout in the same cycle → treated as done; no error.
- DONE: step_done ← 0, busy ← 0, → IDLE. spike_count holds until the next accepted tick.
- synap_con_done outside WAIT is ignored.
- tick while busy (SCAN/WAIT/DONE) is ignored: buffer unchanged, tick_overrun ← 1.
- err_clr=1 clears both sticky flags. A simultaneous set event wins: the flag stays 1.
- Index arithmetic is $clog2(NUM_AXONS) bits; it never wraps within a step because the last-index checks precede increment.

## Timing
- Edge E0 samples tick. From E1, the scan examines one index per cycle.
- Empty vector: step_done is high in the cycle after edge E(NUM_AXONS), i.e. NUM_AXONS cycles after the tick edge. busy falls one cycle later. A new tick is accepted on the edge where busy is already 0, so the minimum step period is NUM_AXONS+2 cycles.
- Each spiking axon adds exactly its WAIT residency, measured from the enable-rising edge through the edge that samples done. This is ≥ 1 and ≤ TIMEOUT cycles.
- synap_enable rises on the edge that leaves SCAN. It falls on the edge that samples done or timeout. It is never high for two different axon numbers without at least one low cycle between them.

## Test plan
- Empty vector, NUM_AXONS=256: tick → no synap_enable; step_done pulse exactly 256 cycles after the tick edge; spike_count=0.
- Spikes at axons 0, 7, 255, done returned 3 cycles after each enable: axon_number sequence 0, 7, 255; each enable high 3 cycles; step_done at 256+9 cycles; spike_count=3.
- All 256 axons spiking, done returned 1 cycle after enable: 256 issues in ascending order; step_done at 512 cycles; spike_count=256.
- Axon 5 only, done never returned, TIMEOUT=16: enable held 16 cycles then drops; timeout_err=1; step_done still pulses; err_clr clears the flag.
- tick reasserted during WAIT with a different vector: tick_overrun=1; issued axons match the first vector only.
- rst driven low mid-WAIT: next cycle all outputs at reset values, no step_done; a fresh tick then runs a complete normal step.
